// File: rtl/data_sram_slave_if.sv
// data_sram request/addr_ok/data_ok bus between the EXE-stage master and the data memory responder.
// The master holds req/wr/size/wstrb/addr/wdata stable until addr_ok; data_ok/rdata are never back-pressured.
interface data_sram_slave_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// Data memory responder: up to DEPTH requests outstanding, in-order responses no earlier than LATENCY cycles after acceptance.
// addr_ok drops while full, data_ok is never back-pressured; DATA_SRAM_SLAVE_STALL_EN adds pseudo-random accept/response stalls.
module data_sram_slave #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_slave_if.slave  bus
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0]     TMR_INIT = 4'(LATENCY - 1);

  logic [31:0]       mem     [0:(2**ADDR_W)-1];
  logic [31:0]       ent_dat [DEPTH];
  logic              ent_rd  [DEPTH];
  logic [3:0]        ent_tmr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              rst_done;
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic              stall_acc;
  logic              stall_rsp;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  assign idx         = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

`ifdef DATA_SRAM_SLAVE_STALL_EN
  logic [15:0] lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting right
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign stall_acc = lfsr[0];
  assign stall_rsp = lfsr[1];
`else
  assign stall_acc = 1'b0;
  assign stall_rsp = 1'b0;
`endif

  // rst_done keeps addr_ok low while reset is held, even though count reads zero
  assign bus.data_sram_addr_ok = rst_done & (count < FULL_CNT) & ~stall_acc;
  assign bus.data_sram_data_ok = data_ok_q;
  assign bus.data_sram_rdata   = rdata_q;

  assign push = bus.data_sram_req & bus.data_sram_addr_ok;
  assign pop  = (count != '0) & (ent_tmr[rd_ptr] == 4'd0) & ~stall_rsp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_done  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tmr[i] <= '0;
        ent_rd[i]  <= 1'b0;
      end
    end else begin
      rst_done <= 1'b1;
      if (push) begin
        wr_ptr         <= wr_ptr + 1'b1;
        ent_rd[wr_ptr] <= ~bus.data_sram_wr;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      data_ok_q <= pop;
      rdata_q   <= (pop && ent_rd[rd_ptr]) ? ent_dat[rd_ptr] : 32'h0;
      // timers of every slot count down; the one being pushed reloads
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == PTR_W'(i)) ent_tmr[i] <= TMR_INIT;
        else if (ent_tmr[i] != 4'd0)     ent_tmr[i] <= ent_tmr[i] - 4'd1;
      end
    end
  end

  // Array and captured read data are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      if (bus.data_sram_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.data_sram_wstrb[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end else begin
        ent_dat[wr_ptr] <= mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: instance A (LATENCY 2) runs directed and random traffic against a reference model,
// instance B (LATENCY 8) covers the full-FIFO and reset-during-flight cases.
module tb_data_sram_slave;

  localparam int LAT_A = 2;
  localparam int LAT_B = 8;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } resp_t;

  logic clk = 1'b0;
  logic resetn_a = 1'b1;
  logic resetn_b = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_resp_a = 0;
  int   b_ok_cnt = 0;

  resp_t       exp_q[$];
  resp_t       obs_q[$];
  logic [31:0] ref_mem [4096];
  logic        mon_ok;
  logic [31:0] mon_dat;

  data_sram_slave_if a_if ();
  data_sram_slave_if b_if ();

  data_sram_slave #(.ADDR_W(12), .DEPTH(4), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .resetn(resetn_a), .bus(a_if.slave)
  );
  data_sram_slave #(.ADDR_W(12), .DEPTH(4), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .resetn(resetn_b), .bus(b_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Every cycle A's outputs must match the model's next due response (or be idle zeros).
  always @(negedge clk) begin
    mon_ok  = 1'b0;
    mon_dat = 32'h0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_ok  = 1'b1;
      mon_dat = exp_q[0].dat;
      void'(exp_q.pop_front());
    end
    chk("a_data_ok", 32'(a_if.data_sram_data_ok), 32'(mon_ok));
    chk("a_rdata", a_if.data_sram_rdata, mon_dat);
    if (a_if.data_sram_data_ok) obs_q.push_back('{cyc: cyc, dat: a_if.data_sram_rdata});
  end

  always @(negedge clk) if (b_if.data_sram_data_ok) b_ok_cnt++;

  // Model: memory acts in acceptance order; response due at max(accept+LAT, previous+1).
  task automatic issue_a(input bit w, input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] s, output int acc);
    int          t;
    int          due;
    logic [31:0] rd;
    a_if.data_sram_req   = 1'b1;
    a_if.data_sram_wr    = w;
    a_if.data_sram_size  = 2'd2;
    a_if.data_sram_addr  = ad;
    a_if.data_sram_wdata = d;
    a_if.data_sram_wstrb = s;
    t = 0;
    while (!a_if.data_sram_addr_ok && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("a_accept_in_time", 32'(t < 100), 32'h1);
    acc = cyc + 1;
    rd  = 32'h0;
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[ad[13:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      rd = ref_mem[ad[13:2]];
    end
    due = acc + LAT_A;
    if (due <= last_resp_a) due = last_resp_a + 1;
    last_resp_a = due;
    exp_q.push_back('{cyc: due, dat: rd});
    @(negedge clk);
    a_if.data_sram_req = 1'b0;
  endtask

  task automatic issue_b(input bit w, input logic [31:0] ad, input logic [31:0] d, output int acc);
    int t;
    b_if.data_sram_req   = 1'b1;
    b_if.data_sram_wr    = w;
    b_if.data_sram_size  = 2'd2;
    b_if.data_sram_addr  = ad;
    b_if.data_sram_wdata = d;
    b_if.data_sram_wstrb = 4'hF;
    t = 0;
    while (!b_if.data_sram_addr_ok && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b_accept_in_time", 32'(t < 100), 32'h1);
    acc = cyc + 1;
    @(negedge clk);
    b_if.data_sram_req = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("a_responses_arrived", 32'(obs_q.size() >= n), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required below 20000", cyc);
    $fatal(1);
  end

  initial begin
    int          t0, t1, hs, first_cyc, base;
    int          acc_b[8];
    logic [31:0] ad;
    a_if.data_sram_req = 1'b0; a_if.data_sram_wr = 1'b0; a_if.data_sram_size = 2'd0;
    a_if.data_sram_wstrb = 4'h0; a_if.data_sram_addr = 32'h0; a_if.data_sram_wdata = 32'h0;
    b_if.data_sram_req = 1'b0; b_if.data_sram_wr = 1'b0; b_if.data_sram_size = 2'd0;
    b_if.data_sram_wstrb = 4'h0; b_if.data_sram_addr = 32'h0; b_if.data_sram_wdata = 32'h0;

    // reset with no clock edge yet
    #1 resetn_a = 1'b0; resetn_b = 1'b0;
    #1;
    chk("rst_addr_ok", 32'(a_if.data_sram_addr_ok), 32'h0);
    chk("rst_data_ok", 32'(a_if.data_sram_data_ok), 32'h0);
    chk("rst_rdata", a_if.data_sram_rdata, 32'h0);
    chk("rst_b_addr_ok", 32'(b_if.data_sram_addr_ok), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_clocked_addr_ok", 32'(a_if.data_sram_addr_ok), 32'h0);
    resetn_a = 1'b1; resetn_b = 1'b1;
    @(negedge clk);
    chk("release_addr_ok", 32'(a_if.data_sram_addr_ok), 32'h1);
    chk("release_b_addr_ok", 32'(b_if.data_sram_addr_ok), 32'h1);

    // word write then read-after-write, back to back
    obs_q.delete();
    issue_a(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, t0);
    issue_a(1'b0, 32'h100, 32'h0, 4'h0, t1);
    wait_obs(2);
    chk("raw_back_to_back", t1, t0 + 1);
    chk("raw_wr_resp_cyc", obs_q[0].cyc, t0 + 2);
    chk("raw_wr_resp_dat", obs_q[0].dat, 32'h0);
    chk("raw_rd_resp_cyc", obs_q[1].cyc, t0 + 3);
    chk("raw_rd_resp_dat", obs_q[1].dat, 32'hDEADBEEF);

    // byte strobe, then a strobe-less write that must change nothing
    obs_q.delete();
    issue_a(1'b1, 32'h200, 32'h11223344, 4'hF, t0);
    issue_a(1'b1, 32'h200, 32'hAAAAAAAA, 4'b0100, t0);
    issue_a(1'b0, 32'h200, 32'h0, 4'h0, t0);
    issue_a(1'b1, 32'h200, 32'hFFFFFFFF, 4'h0, t0);
    issue_a(1'b0, 32'h203, 32'h0, 4'h0, t0);
    wait_obs(5);
    chk("strobe_rd", obs_q[2].dat, 32'h11AA3344);
    chk("strobe0_rd", obs_q[4].dat, 32'h11AA3344);

    // aliasing above the array size
    obs_q.delete();
    issue_a(1'b1, 32'h00004004, 32'h5A5A5A5A, 4'hF, t0);
    issue_a(1'b0, 32'h00000004, 32'h0, 4'h0, t0);
    wait_obs(2);
    chk("alias_rd", obs_q[1].dat, 32'h5A5A5A5A);

    // random traffic over 16 words with aliased upper bits
    for (int i = 0; i < 16; i++) issue_a(1'b1, 32'(i * 4), $urandom, 4'hF, t0);
    for (int k = 0; k < 200; k++) begin
      ad = (32'($urandom_range(0, 7)) << 14) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      issue_a(1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)), t0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
    chk("a_drained", exp_q.size(), 32'h0);

    // full FIFO on the LATENCY 8 instance
    for (int i = 0; i < 4; i++) issue_b(1'b1, 32'h40 + 32'(i * 4), 32'hB0000000 + 32'(i), t0);
    repeat (20) @(negedge clk);
    b_if.data_sram_wr  = 1'b0;
    b_if.data_sram_req = 1'b1;
    hs = 0;
    for (int k = 0; k < 30; k++) begin
      if (b_if.data_sram_data_ok) break;
      b_if.data_sram_addr = 32'h40 + 32'((hs % 4) * 4);
      if (b_if.data_sram_addr_ok) begin
        if (hs < 8) acc_b[hs] = cyc + 1;
        hs++;
      end
      @(negedge clk);
    end
    b_if.data_sram_req = 1'b0;
    first_cyc = cyc;
    chk("full_handshakes", hs, 4);
    for (int i = 1; i < 4; i++) chk("full_consecutive_accept", acc_b[i], acc_b[0] + i);
    chk("full_first_resp_cyc", first_cyc, acc_b[0] + LAT_B);
    chk("full_resp0", b_if.data_sram_rdata, 32'hB0000000);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) chk("full_addr_ok_reopens", 32'(b_if.data_sram_addr_ok), 32'h1);
      chk("full_resp_ok", 32'(b_if.data_sram_data_ok), 32'h1);
      chk("full_resp_dat", b_if.data_sram_rdata, 32'hB0000000 + 32'(i));
    end
    @(negedge clk);
    chk("full_resp_end", 32'(b_if.data_sram_data_ok), 32'h0);

    // reset while three reads are in flight
    issue_b(1'b0, 32'h40, 32'h0, t0);
    issue_b(1'b0, 32'h44, 32'h0, t0);
    issue_b(1'b0, 32'h48, 32'h0, t0);
    base = b_ok_cnt;
    resetn_b = 1'b0;
    #1;
    chk("midrst_addr_ok", 32'(b_if.data_sram_addr_ok), 32'h0);
    repeat (2) @(negedge clk);
    resetn_b = 1'b1;
    @(negedge clk);
    chk("midrst_release_addr_ok", 32'(b_if.data_sram_addr_ok), 32'h1);
    repeat (20) @(negedge clk);
    chk("midrst_no_stale_resp", b_ok_cnt, base);
    issue_b(1'b0, 32'h4C, 32'h0, t1);
    for (int k = 0; k < 20 && !b_if.data_sram_data_ok; k++) @(negedge clk);
    chk("midrst_fresh_cyc", cyc, t1 + LAT_B);
    chk("midrst_fresh_dat", b_if.data_sram_rdata, 32'hB0000003);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
